// File: rtl/mem_skew_buffer.sv
// Per-lane skew/deskew delay line for the systolic array edge.
// Lane i taps its shift register at a mode-dependent depth; mode changes wait for a drained pipeline.
module mem_skew_buffer #(
  parameter int BITS_AB    = 8,
  parameter int DIM        = 8,
  parameter int BASE_DELAY = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          flush,
  input  logic                          vin,
  input  logic [DIM-1:0][BITS_AB-1:0]   Bin,
  input  logic                          mode_ld,
  input  logic                          mode_in,
  output logic                          ready,
  output logic                          busy,
  output logic                          mode,
  output logic [DIM-1:0]                vout,
  output logic [DIM-1:0][BITS_AB-1:0]   Bout,
  output logic [1:0]                    state_dbg
);

  localparam int MAXD = BASE_DELAY + DIM - 1;
  localparam int TW   = (MAXD > 1) ? $clog2(MAXD) : 1;

  // Handshake: a sample is taken on a rising edge when vin && ready && en && !flush;
  // ready depends only on registered state, so it may be sampled before vin is driven.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PEND = 2'd2} state_t;

  state_t             state, state_nxt;
  logic               mode_nxt, pend, pend_nxt;
  logic               accept;
  logic [MAXD-1:0]    vld [DIM];
  logic [BITS_AB-1:0] dat [DIM][MAXD];
  logic [TW-1:0]      tap [DIM];

  assign ready     = (state != PEND);
  assign accept    = vin & ready & en & ~flush;
  assign state_dbg = state;

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < DIM; i++) begin
      busy = busy | (|vld[i]);
    end
  end

  always_comb begin
    state_nxt = state;
    mode_nxt  = mode;
    pend_nxt  = pend;
    if (flush) begin
      state_nxt = IDLE;
      pend_nxt  = 1'b0;
      if (mode_ld)           mode_nxt = mode_in;
      else if (state == PEND) mode_nxt = pend;
    end else begin
      case (state)
        IDLE: begin
          if (mode_ld) mode_nxt = mode_in;
          if (accept)  state_nxt = RUN;
        end
        RUN: begin
          if (mode_ld) begin
            pend_nxt  = mode_in;
            state_nxt = PEND;
          end else if (!busy && !accept) begin
            state_nxt = IDLE;
          end
        end
        PEND: begin
          if (mode_ld) pend_nxt = mode_in;
          // Apply the newest request even if it lands on the draining edge.
          if (!busy) begin
            mode_nxt  = mode_ld ? mode_in : pend;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mode  <= 1'b0;
      pend  <= 1'b0;
    end else begin
      state <= state_nxt;
      mode  <= mode_nxt;
      pend  <= pend_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DIM; i++) begin
        for (int s = 0; s < MAXD; s++) begin
          vld[i][s] <= 1'b0;
          dat[i][s] <= '0;
        end
      end
    end else if (en) begin
      for (int i = 0; i < DIM; i++) begin
        vld[i][0] <= accept;
        dat[i][0] <= Bin[i];
        for (int s = 1; s < MAXD; s++) begin
          vld[i][s] <= vld[i][s-1];
          dat[i][s] <= dat[i][s-1];
        end
      end
    end
  end

  // Tap index is stage D_i, i.e. zero-based D_i-1.
  always_comb begin
    for (int i = 0; i < DIM; i++) begin
      tap[i]  = mode ? TW'(BASE_DELAY - 1 + DIM - 1 - i) : TW'(BASE_DELAY - 1 + i);
      vout[i] = vld[i][tap[i]];
      Bout[i] = vld[i][tap[i]] ? dat[i][tap[i]] : '0;
    end
  end

endmodule

// File: tb/tb_mem_skew_buffer.sv
// Directed bench for mem_skew_buffer at DIM=4, BASE_DELAY=1, BITS_AB=8.
module tb_mem_skew_buffer;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PEND = 2'd2;

  logic            clk = 1'b0;
  logic            rst, en, flush, vin, mode_ld, mode_in;
  logic [3:0][7:0] bin, bout;
  logic            ready, busy, mode;
  logic [3:0]      vout;
  logic [1:0]      state_dbg;

  int checks = 0;
  int errors = 0;

  // Lane3..lane0 = {-4, 3, -2, 1}
  localparam logic [31:0] VEC = 32'hFC03FE01;

  always #5 clk = ~clk;

  mem_skew_buffer #(.BITS_AB(8), .DIM(4), .BASE_DELAY(1)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .vin(vin), .Bin(bin),
    .mode_ld(mode_ld), .mode_in(mode_in), .ready(ready), .busy(busy),
    .mode(mode), .vout(vout), .Bout(bout), .state_dbg(state_dbg)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    vin = 1'b0; mode_ld = 1'b0; flush = 1'b0; en = 1'b1;
    bin = $urandom_range(32'hFFFF_FFFF, 0);
  endtask

  task automatic out(input string tag, input logic [3:0] ev, input logic [31:0] eb);
    chk({tag, "_vout"}, {28'd0, vout}, {28'd0, ev});
    chk({tag, "_bout"}, bout, eb);
  endtask

  initial begin
    rst = 1'b1; mode_in = 1'b0;
    quiet();
    step();
    rst = 1'b0;
    // 1 reset
    out("rst", 4'b0000, 32'h0);
    chk("rst_mode", {31'd0, mode}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_state", {30'd0, state_dbg}, {30'd0, S_IDLE});

    // 2 skew
    vin = 1'b1; bin = VEC; step(); quiet();
    out("sk1", 4'b0001, 32'h0000_0001);
    chk("sk1_busy", {31'd0, busy}, 32'd1);
    chk("sk1_state", {30'd0, state_dbg}, {30'd0, S_RUN});
    step(); out("sk2", 4'b0010, 32'h0000_FE00);
    step(); out("sk3", 4'b0100, 32'h0003_0000);
    step(); out("sk4", 4'b1000, 32'hFC00_0000);
    step(); out("sk5", 4'b0000, 32'h0);
    chk("sk5_busy", {31'd0, busy}, 32'd0);
    step(); chk("sk6_state", {30'd0, state_dbg}, {30'd0, S_IDLE});

    // 3 deskew
    mode_ld = 1'b1; mode_in = 1'b1; step(); quiet();
    chk("ds_mode", {31'd0, mode}, 32'd1);
    chk("ds_state", {30'd0, state_dbg}, {30'd0, S_IDLE});
    vin = 1'b1; bin = VEC; step(); quiet();
    out("ds1", 4'b1000, 32'hFC00_0000);
    step(); out("ds2", 4'b0100, 32'h0003_0000);
    step(); out("ds3", 4'b0010, 32'h0000_FE00);
    step(); out("ds4", 4'b0001, 32'h0000_0001);
    step(); out("ds5", 4'b0000, 32'h0);
    step(); chk("ds6_state", {30'd0, state_dbg}, {30'd0, S_IDLE});
    mode_ld = 1'b1; mode_in = 1'b0; step(); quiet();
    chk("back_to_skew", {31'd0, mode}, 32'd0);

    // 4 stall: en low for edges 2..4, plus a vin with en=0 that must be dropped
    vin = 1'b1; bin = VEC; step(); quiet();
    out("st1", 4'b0001, 32'h0000_0001);
    step(); out("st2", 4'b0010, 32'h0000_FE00);
    en = 1'b0; step();
    out("st3", 4'b0010, 32'h0000_FE00);
    vin = 1'b1; bin = 32'h1111_1111; step(); vin = 1'b0;
    out("st4", 4'b0010, 32'h0000_FE00);
    step(); out("st5", 4'b0010, 32'h0000_FE00);
    en = 1'b1; step(); out("st6", 4'b0100, 32'h0003_0000);
    step(); out("st7", 4'b1000, 32'hFC00_0000);
    step(); out("st8", 4'b0000, 32'h0);
    step(); chk("st9_state", {30'd0, state_dbg}, {30'd0, S_IDLE});

    // 5 deferred mode change
    vin = 1'b1; bin = VEC; step(); quiet();
    mode_ld = 1'b1; mode_in = 1'b1; step(); quiet();
    chk("df2_ready", {31'd0, ready}, 32'd0);
    chk("df2_state", {30'd0, state_dbg}, {30'd0, S_PEND});
    out("df2", 4'b0010, 32'h0000_FE00);
    vin = 1'b1; bin = 32'h2222_2222; step(); quiet();
    out("df3", 4'b0100, 32'h0003_0000);
    vin = 1'b1; bin = 32'h3333_3333; step(); quiet();
    out("df4", 4'b1000, 32'hFC00_0000);
    chk("df4_mode", {31'd0, mode}, 32'd0);
    step();
    chk("df5_busy", {31'd0, busy}, 32'd0);
    chk("df5_mode", {31'd0, mode}, 32'd0);
    chk("df5_ready", {31'd0, ready}, 32'd0);
    step();
    chk("df6_mode", {31'd0, mode}, 32'd1);
    chk("df6_ready", {31'd0, ready}, 32'd1);
    chk("df6_state", {30'd0, state_dbg}, {30'd0, S_IDLE});
    out("df6", 4'b0000, 32'h0);

    // 6 flush with three samples in flight (deskew) and a pending mode of 0
    vin = 1'b1; bin = 32'h0A0B_0C0D; step();
    bin = 32'h1A1B_1C1D; step();
    bin = 32'h2A2B_2C2D; mode_ld = 1'b1; mode_in = 1'b0; step(); quiet();
    chk("fl3_state", {30'd0, state_dbg}, {30'd0, S_PEND});
    out("fl3", 4'b1110, 32'h2A1B_0C00);
    flush = 1'b1; vin = 1'b1; bin = 32'h7F7F_7F7F; step(); quiet();
    out("fl4", 4'b0000, 32'h0);
    chk("fl4_busy", {31'd0, busy}, 32'd0);
    chk("fl4_mode", {31'd0, mode}, 32'd0);
    chk("fl4_state", {30'd0, state_dbg}, {30'd0, S_IDLE});
    chk("fl4_ready", {31'd0, ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      step();
      out("fl_after", 4'b0000, 32'h0);
      chk("fl_after_busy", {31'd0, busy}, 32'd0);
    end
    flush = 1'b1; mode_ld = 1'b1; mode_in = 1'b1; step(); quiet();
    chk("fl_mode_ld", {31'd0, mode}, 32'd1);

    // reset mid-operation discards data and the pending mode
    vin = 1'b1; bin = VEC; step(); quiet();
    mode_ld = 1'b1; mode_in = 1'b0; step(); quiet();
    rst = 1'b1; step(); rst = 1'b0;
    out("mr", 4'b0000, 32'h0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_mode", {31'd0, mode}, 32'd0);
    chk("mr_state", {30'd0, state_dbg}, {30'd0, S_IDLE});
    step(); step();
    chk("mr_mode_hold", {31'd0, mode}, 32'd0);
    out("mr_hold", 4'b0000, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
